// File: rtl/cpu0_fetch_unit.sv
// cpu0 fetch/prefetch stage: single-outstanding memory reads into a small FIFO.
// Define FETCH_STATS_EN to add redirect_cnt_o, a saturating count of issued JUMPs.
module cpu0_fetch_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              pon_rst_n_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              cpu_halt_i,
  output logic [DATA_W-1:0] instruction_o,
  output logic              instr_valid_o,
`ifdef FETCH_STATS_EN
  output logic [7:0]        redirect_cnt_o,
`endif
  output logic              fetch_idle_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              drop_q;

  logic [DATA_W-1:0] head;
  logic [3:0]        opc;
  logic              issue, is_jump, is_halt, flush;
  logic              resp, push, can_fetch;

  assign head  = fifo_q[rd_ptr_q];
  assign opc   = head[DATA_W-1 -: 4];
  assign issue = (cnt_q != '0) && !cpu_halt_i && (state_q == RUN);

  assign is_jump = issue && (opc == 4'b0100);
  assign is_halt = issue && (opc == 4'b1111);
  assign flush   = is_jump || is_halt;

  assign resp = mem_req_o && mem_ack_i;
  assign push = resp && !drop_q && !flush;

  assign instr_valid_o = issue;
  assign instruction_o = issue ? head : '0;
  assign fetch_idle_o  = !mem_req_o && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (is_halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) state_q <= RUN;
    else              state_q <= state_d;
  end

  // A dropped response does not advance fetch_pc: it already points at the redirect target.
  always_comb begin
    pc_d = pc_q;
    if (is_jump)
      pc_d = head[ADDR_W-1:0];
    else if (resp && !drop_q)
      pc_d = pc_q + ADDR_W'(1);
  end

  assign can_fetch = !mem_req_o && (state_d == RUN) &&
                     (cnt_q < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      pc_q       <= '0;
      drop_q     <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (mem_req_o) begin
        if (mem_ack_i) mem_req_o <= 1'b0;
      end else if (can_fetch) begin
        mem_req_o  <= 1'b1;
        mem_addr_o <= pc_d;
      end
      if (resp)
        drop_q <= 1'b0;
      else if (mem_req_o && flush)
        drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !issue)
        cnt_q <= cnt_q + CNT_W'(1);
      else if (issue && !push)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

`ifdef FETCH_STATS_EN
  logic [7:0] rc_q;

  always_ff @(posedge clk or negedge pon_rst_n_i) begin
    if (!pon_rst_n_i)
      rc_q <= 8'd0;
    else if (is_jump && (rc_q != 8'hFF))
      rc_q <= rc_q + 8'd1;
  end

  assign redirect_cnt_o = rc_q;
`endif

endmodule

// File: tb/tb_cpu0_fetch_unit.sv
// Bench for cpu0_fetch_unit: behavioural queue model, directed scenarios, random programs.
// Builds with or without FETCH_STATS_EN.
`timescale 1ns/1ps
module tb_cpu0_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_req, mem_ack = 1'b0;
  logic [12:0] mem_addr;
  logic [15:0] mem_rdata = 16'h0;
  logic        cpu_halt = 1'b0;
  logic [15:0] instruction;
  logic        instr_valid, fetch_idle;
`ifdef FETCH_STATS_EN
  logic [7:0]  redirect_cnt;
`endif

  cpu0_fetch_unit #(.FIFO_DEPTH(DEPTH), .ADDR_W(13), .DATA_W(16)) dut (
    .clk           (clk),
    .pon_rst_n_i   (rst_n),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .cpu_halt_i    (cpu_halt),
    .instruction_o (instruction),
    .instr_valid_o (instr_valid),
`ifdef FETCH_STATS_EN
    .redirect_cnt_o(redirect_cnt),
`endif
    .fetch_idle_o  (fetch_idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  logic [15:0] prog [8192];
  int          lat = 1;
  bit          spur = 1'b0;
  bit          halt_v = 1'b0;
  int          wcnt = 0;
  int          acks = 0;
  logic [15:0] ilog [$];
  logic [12:0] alog [$];

  // Reference model: FIFO as a queue, fetch/issue rules applied per clock.
  logic [15:0] mq [$];
  bit          m_req = 1'b0, m_drop = 1'b0, m_run = 1'b1;
  logic [12:0] m_addr = 13'h0, m_pc = 13'h0;
  int          m_rc = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] hd;
    logic [12:0] npc;
    bit v, j, h, got;
    int c0;
    if (!rst_n) begin
      mq.delete();
      m_req = 0; m_addr = 0; m_pc = 0; m_drop = 0; m_run = 1; m_rc = 0;
    end else begin
      c0  = mq.size();
      v   = m_run && !cpu_halt && c0 > 0;
      hd  = v ? mq[0] : 16'h0;
      j   = v && hd[15:12] == 4'h4;
      h   = v && hd[15:12] == 4'hF;
      got = m_req && mem_ack;
      if (v) void'(mq.pop_front());
      if (got && !m_drop) mq.push_back(mem_rdata);
      if (j || h) mq.delete();
      npc = m_pc;
      if (got && !m_drop) npc = m_pc + 13'd1;
      if (j) npc = hd[12:0];
      if (h) m_run = 0;
      if (got) m_drop = 0;
      else if (m_req && (j || h)) m_drop = 1;
      if (m_req) begin
        if (got) m_req = 0;
      end else if (m_run && c0 < DEPTH) begin
        m_req = 1;
        m_addr = npc;
      end
      if (j && m_rc < 255) m_rc++;
      m_pc = npc;
    end
  end

  always @(negedge clk) begin
    bit          ev;
    logic [15:0] ei;
    #2;
    ev = m_run && !cpu_halt && mq.size() > 0;
    ei = ev ? mq[0] : 16'h0;
    chk("req", mem_req, m_req);
    if (m_req) chk("addr", mem_addr, m_addr);
    chk("valid", instr_valid, ev);
    chk("instr", instruction, ei);
    chk("idle", fetch_idle, !m_req && mq.size() == 0);
`ifdef FETCH_STATS_EN
    chk("redirect_cnt", redirect_cnt, m_rc[7:0]);
`endif
    if (instr_valid) ilog.push_back(instruction);
  end

  task automatic tick();
    @(negedge clk);
    if (mem_req && rst_n) begin
      if (wcnt >= lat - 1) begin
        mem_ack = 1'b1;
        mem_rdata = prog[mem_addr];
        wcnt = 0;
        acks++;
        alog.push_back(mem_addr);
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      mem_ack = spur && ($urandom_range(7) == 0);
      mem_rdata = 16'($urandom);
    end
    cpu_halt = halt_v;
    #3;
  endtask

  task automatic clear_logs();
    ilog.delete();
    alog.delete();
    acks = 0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic nop_prog();
    for (int a = 0; a < 8192; a++) prog[a] = {3'b000, 13'(a)};
  endtask

  initial begin
    bit          found;
    logic [15:0] prev;
    int          n;
    nop_prog();
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_idle", fetch_idle, 1);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    rst_n = 1'b1;
    clear_logs();

    // straight-line stream
    lat = 1;
    repeat (40) tick();
    for (int i = 0; i < 8; i++) chk("stream_order", ilog[i], i);

    // halted core: FIFO fills with exactly four words
    lat = 5; halt_v = 1;
    reset_dut();
    repeat (30) tick();
    chk("halt_fill_acks", acks, 4);
    chk("halt_fill_req", mem_req, 0);
    chk("halt_fill_idle", fetch_idle, 0);
    halt_v = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("release_valid", instr_valid, 1);
      chk("release_instr", instruction, i);
    end

    // JUMP with a request outstanding
    nop_prog();
    prog[2] = 16'h4010;
    prog[16] = 16'h0ABC;
    lat = 3; halt_v = 1;
    reset_dut();
    repeat (24) tick();
    halt_v = 0; tick();
    halt_v = 1; repeat (8) tick();
    halt_v = 0; tick();
    halt_v = 1; tick();
    halt_v = 0; repeat (30) tick();
    chk("jump_i0", ilog[0], 16'h0000);
    chk("jump_i1", ilog[1], 16'h0001);
    chk("jump_i2", ilog[2], 16'h4010);
    chk("jump_target", ilog[3], 16'h0ABC);
    chk("jump_pend_addr", alog[5], 13'h005);
    chk("jump_next_addr", alog[6], 13'h010);
`ifdef FETCH_STATS_EN
    chk("jump_cnt", redirect_cnt, 1);
`endif

    // HALT
    nop_prog();
    prog[1] = 16'hF000;
    lat = 2;
    reset_dut();
    repeat (40) tick();
    chk("halt_issued", ilog.size(), 2);
    chk("halt_word", ilog[1], 16'hF000);
    chk("halt_req", mem_req, 0);
    chk("halt_idle", fetch_idle, 1);
    chk("halt_valid", instr_valid, 0);

    // address wrap 0x1FFF -> 0x0000
    nop_prog();
    prog[0] = 16'h4FFF;
    lat = 1;
    reset_dut();
    found = 0; prev = 16'h0;
    for (int i = 0; i < 12000 && !found; i++) begin
      tick();
      if (instr_valid) begin
        if (prev == 16'h1FFF && instruction == 16'h4FFF) found = 1;
        prev = instruction;
      end
      if (ilog.size() > 64) ilog.delete();
    end
    chk("wrap_seen", found, 1);

`ifdef FETCH_STATS_EN
    nop_prog();
    prog[0] = 16'h4000;
    lat = 1;
    reset_dut();
    repeat (1500) tick();
    chk("redirect_sat", redirect_cnt, 8'hFF);
`endif

    // reset mid-request with a late ack
    nop_prog();
    lat = 3;
    reset_dut();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (mem_req && mem_addr == 13'd7) found = 1;
    end
    chk("req7_seen", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    #3;
    chk("midrst_req", mem_req, 0);
    chk("midrst_idle", fetch_idle, 1);
    chk("midrst_valid", instr_valid, 0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (30) tick();
    chk("post_rst_addr", alog[0], 0);
    chk("post_rst_first", ilog[0], 0);
    n = 0;
    foreach (ilog[i]) if (ilog[i] == 16'hDEAD) n++;
    chk("stale_issued", n, 0);

    // random programs, latencies, halts and spurious acks
    spur = 1;
    for (int r = 0; r < 6; r++) begin
      int rst_at;
      nop_prog();
      for (int a = 0; a < 256; a++) begin
        int k;
        k = $urandom_range(63);
        if (k < 3) prog[a] = {8'h40, 8'($urandom)};
        else if (k == 3 && r[0]) prog[a] = 16'hF000;
        else prog[a] = {4'h0, 12'($urandom)};
      end
      lat = $urandom_range(4, 1);
      reset_dut();
      rst_at = $urandom_range(400, 100);
      for (int i = 0; i < 500; i++) begin
        halt_v = ($urandom_range(3) == 0);
        if (i == rst_at) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
        end else begin
          tick();
        end
        if (ilog.size() > 64) ilog.delete();
        if (alog.size() > 64) alog.delete();
      end
    end
    spur = 0;
    halt_v = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu0_fetch_unit.md
Name: cpu0_fetch_unit

Overview:
Instruction fetch/prefetch stage placed directly upstream of the cpu0 host core. It reads 16-bit instructions from program memory over a single-outstanding req/ack handshake and buffers them in a small FIFO. It presents one instruction per cycle on instruction_o/instr_valid_o, which the core consumes unconditionally. It tracks issued JUMP/HALT opcodes so that fetch redirects and stops in step with the core.

Parameters:
FIFO_DEPTH, 4, prefetch buffer entries (power of 2, 2..16)
ADDR_W, 13, program address width
DATA_W, 16, instruction width

Ports:
clk  input  1  clock
pon_rst_n_i  input  1  asynchronous active-low reset
mem_req_o  output  1  fetch request, held until mem_ack_i
mem_addr_o  output  ADDR_W  fetch address, stable while mem_req_o=1
mem_ack_i  input  1  memory response strobe; mem_rdata_i valid this cycle
mem_rdata_i  input  DATA_W  fetched instruction
cpu_halt_i  input  1  core halted; suppresses issue
instruction_o  output  DATA_W  FIFO head instruction
instr_valid_o  output  1  instruction_o is issued this cycle
fetch_idle_o  output  1  1 when no request is outstanding and FIFO is empty

Behaviour:
- Reset (async, pon_rst_n_i=0): mem_req_o=0, mem_addr_o=0, FIFO empty, instr_valid_o=0, instruction_o=0, fetch_idle_o=1, drop flag=0, state=RUN. Reset mid-request abandons the request; a late mem_ack_i after reset with mem_req_o=0 is ignored.
- Clocking: all state updates on posedge clk. instr_valid_o and instruction_o are combinational from FIFO head and state. instruction_o=0 whenever instr_valid_o=0.
- Issue rule: instr_valid_o = FIFO non-empty && !cpu_halt_i && state==RUN. Every cycle with instr_valid_o=1 pops the head. There is no ready signal.
- Fetch rule: in RUN, when mem_req_o=0 and (count + pending) < FIFO_DEPTH, assert mem_req_o next cycle with mem_addr_o=fetch_pc. pending=1 while mem_req_o=1. At most one outstanding request.
- Response: on mem_req_o && mem_ack_i, push mem_rdata_i (unless drop flag set), fetch_pc <= fetch_pc+1 (wraps 0x1FFF -> 0x0000), and deassert mem_req_o for at least one cycle. First data is issuable the cycle after the ack.
- Simultaneous push and pop: count unchanged. A push is never attempted when full (guaranteed by the fetch rule).
- JUMP (issued instruction[15:12]==4'b0100): in the same cycle flush the FIFO (including any same-cycle push) and set fetch_pc <= instruction[ADDR_W-1:0].
  - If a request is outstanding, keep mem_req_o/mem_addr_o until ack, discard that data (drop flag), clear the drop flag, then fetch from the target.
  - An ack in the same cycle as a JUMP issue is discarded and the redirect applies immediately.
- HALT (issued instruction[15:12]==4'b1111): state RUN -> HALTED and flush the FIFO. No new requests. An outstanding request completes and its data is discarded. HALTED exits only by reset.
- cpu_halt_i=1: issue stops. Prefetch continues until the FIFO is full.
- States: RUN, HALTED. fetch_idle_o = !mem_req_o && count==0.

Optional Feature:
FETCH_STATS_EN
- Defined: adds output redirect_cnt_o[7:0], a count of JUMP redirects. It resets to 0, increments on each issued JUMP, and saturates at 0xFF.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Straight-line: memory returns data=addr|0x0000 (NOP stream), ack latency 1 -> requests at 0,1,2,…; instr_valid_o streams each word in address order; no gaps beyond handshake turnaround.
- Ack latency 5 cycles, cpu_halt_i=1 for 30 cycles -> exactly 4 requests issued, FIFO full, mem_req_o stays 0. Release -> 4 consecutive valid cycles with addrs 0..3.
- Word at addr 2 = 16'h4010 (JUMP 0x010) with a request to addr 5 outstanding -> entries 3,4 flushed, addr-5 data discarded, next request addr 0x010, next issued instruction is mem[0x010]; redirect_cnt_o=1 if enabled.
- Word at addr 1 = 16'hF000 -> HALTED; instr_valid_o=0 forever; mem_req_o drops after any pending ack; fetch_idle_o=1.
- JUMP to 0x1FFF -> fetches 0x1FFF then 0x0000 (wrap).
- Assert pon_rst_n_i=0 while mem_req_o=1 at addr 7, pulse mem_ack_i during reset -> all outputs reset values, first post-reset request at addr 0, stale data never issued.
